avmm_ddr_arbiter: RTL and testbench
===================================

Name: avmm_ddr_arbiter

Overview:
- Two-master, burst-aware Avalon-MM arbiter that shares one DDR4 bank slave port between the DMA's DDR master and a second AFU master (host MMIO bypass path).
- Sits in the AFU host clock domain, in front of the clock-crossing bridge to the memory controller.
- Grants round-robin per command and locks the grant for the duration of a write burst.
- Tracks outstanding read bursts so read responses return to the master that issued them.

Parameters:
- DATA_WIDTH, 512, data width of readdata/writedata.
- ADDR_WIDTH, 32, byte address width.
- BURST_WIDTH, 3, burstcount width; legal values are 1..4.
- MAX_PENDING_READS, 16, depth of the read-tag FIFO; must be a power of 2.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high.
- m0_waitrequest, m1_waitrequest  out  1  per-master stall.
- m0_readdata, m1_readdata  out  DATA_WIDTH  read data, routed from s_readdata.
- m0_readdatavalid, m1_readdatavalid  out  1  read beat valid for that master.
- m0_address, m1_address  in  ADDR_WIDTH  command address.
- m0_burstcount, m1_burstcount  in  BURST_WIDTH  burst length.
- m0_writedata, m1_writedata  in  DATA_WIDTH  write data.
- m0_byteenable, m1_byteenable  in  DATA_WIDTH/8  byte enables.
- m0_write, m0_read, m1_write, m1_read  in  1  command strobes.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_WIDTH  slave read data.
- s_readdatavalid  in  1  slave read beat valid.
- s_address  out  ADDR_WIDTH  muxed command address.
- s_burstcount  out  BURST_WIDTH  muxed burst length.
- s_writedata  out  DATA_WIDTH  muxed write data.
- s_byteenable  out  DATA_WIDTH/8  muxed byte enables.
- s_write, s_read  out  1  muxed command strobes.

Behaviour:
- Reset values:
  - FSM = IDLE, rr_last = 1 (master 0 wins first), tag FIFO empty, beat counters 0.
  - While reset is high: s_write = s_read = 0, both m*_waitrequest = 1, both m*_readdatavalid = 0.
- FSM state IDLE:
  - sel is chosen combinationally among masters asserting read or write. Round-robin: the master other than rr_last wins on a tie.
  - A master issuing a read while the tag FIFO is full is ineligible.
  - s_* command outputs are driven from sel; m[sel]_waitrequest = s_waitrequest; the other master's waitrequest = 1.
  - With no eligible request: s_write = s_read = 0, both waitrequests = 1.
- Command accept: occurs when s_write or s_read is high and s_waitrequest = 0. On accept, rr_last <= sel.
- Accepted read: push {id = sel, len = burstcount} into the tag FIFO; stay in IDLE.
- Accepted write with burstcount = 1: stay in IDLE.
- Accepted write with burstcount > 1: go to WR_BURST, lock = sel, beats_left = burstcount - 1.
- FSM state WR_BURST:
  - Only the locked master is muxed; the other master's waitrequest = 1.
  - s_read is forced to 0.
  - Each accepted write beat decrements beats_left. The beat accepted when beats_left = 1 returns the FSM to IDLE on the next cycle.
- Read return:
  - m0_readdata = m1_readdata = s_readdata (zero latency).
  - m[head.id]_readdatavalid = s_readdatavalid when the FIFO is non-empty; always 0 when the FIFO is empty.
  - rd_beat counts returned beats; on the beat where rd_beat = head.len - 1, pop the FIFO and clear rd_beat.
  - A pop and a push in the same cycle are both honoured; occupancy is unchanged.
- Boundary conditions:
  - FIFO full blocks read grants only; writes still arbitrate.
  - s_readdatavalid with an empty FIFO is a protocol error; it is dropped and a simulation assertion fires.
  - burstcount = 0 or > 4 is a protocol error (assertion); it is treated as 1.
  - A master must hold its command stable while waitrequest = 1 (Avalon rule; not checked).
  - Reset mid-burst or with reads pending aborts everything immediately. The slave is reset by the same signal.

Optional Feature:
- Macro: AVMM_ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins simultaneous requests in IDLE; rr_last is unused. Write-burst locking is unchanged.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Package avmm_arb_pkg holds:
  - typedef t_arb_id (1 bit);
  - typedef t_rd_tag struct {t_arb_id id; logic [BURST_WIDTH-1:0] len;};
  - enum t_arb_state {IDLE, WR_BURST};
  - constant ARB_NUM_MASTERS = 2.
- Sub-module avmm_arb_tag_fifo:
  - synchronous FIFO of t_rd_tag, depth MAX_PENDING_READS;
  - push/pop/full/empty, show-ahead head;
  - same clk and asynchronous reset.

Test Plan:
- m0 and m1 both issue single-beat writes every cycle, s_waitrequest = 0 -> slave sees alternating m0, m1, m0, m1; each master's waitrequest is 1 on its off cycle.
- m0 issues a 4-beat write at 0x1000 while m1 requests a read -> 4 consecutive m0 beats reach the slave; m1_waitrequest = 1 throughout; the m1 read is granted on cycle 5.
- m0 reads burst 2, then m1 reads burst 3; slave returns 5 beats with 3-cycle latency -> m0_readdatavalid on beats 1-2, m1_readdatavalid on beats 3-5; FIFO ends empty.
- m0 issues 16 reads without any returns -> the 17th read is stalled while an m1 write is still granted; one completed return frees a slot and the read is accepted on the next cycle.
- s_waitrequest high for 10 cycles during beat 2 of a 4-beat write -> lock is held, no switch to m1; the burst completes with exactly 4 beats.
- Assert reset in WR_BURST with 3 reads pending -> immediate s_write = 0, waitrequests = 1, FIFO empty. After release, m0 is granted first.

Source files
------------

// File: rtl/avmm_arb_pkg.sv
// avmm_arb_pkg: shared types and constants for the two-master Avalon-MM DDR arbiter
package avmm_arb_pkg;
  localparam int ARB_NUM_MASTERS = 2;
  localparam int ARB_BURST_WIDTH = 3;
  localparam int ARB_MAX_BURST = 4;
  typedef logic t_arb_id;
  typedef logic [ARB_BURST_WIDTH-1:0] t_len;
  typedef struct packed {
    t_arb_id id;
    t_len    len;
  } t_rd_tag;
  typedef enum logic {IDLE, WR_BURST} t_arb_state;
endpackage

// File: rtl/avmm_arb_tag_fifo.sv
// avmm_arb_tag_fifo: show-ahead FIFO of read tags (clk, async active-high reset, push/push_tag, pop, head, full, empty)
module avmm_arb_tag_fifo
  import avmm_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  t_rd_tag push_tag,
  input  logic    pop,
  output t_rd_tag head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  t_rd_tag mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic do_push, do_pop;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = wp_q == rp_q;
  assign full = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
  assign head = mem_q[rp_q[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_q + (AW+1)'(do_push);
      rp_q <= rp_q + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= push_tag;
endmodule

// File: rtl/avmm_ddr_arbiter.sv
// avmm_ddr_arbiter: two-master burst-aware Avalon-MM arbiter in front of one DDR bank slave
//   clk/reset (async, active-high); m0_*/m1_* Avalon-MM slave ports for the two masters;
//   s_* Avalon-MM master port toward the memory bridge.
//   AVMM_ARB_FIXED_PRIO_EN: master 0 always wins simultaneous requests instead of round-robin.
module avmm_ddr_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_WIDTH = ARB_BURST_WIDTH,
  parameter int MAX_PENDING_READS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    m0_waitrequest,
  output logic                    m1_waitrequest,
  output logic [DATA_WIDTH-1:0]   m0_readdata,
  output logic [DATA_WIDTH-1:0]   m1_readdata,
  output logic                    m0_readdatavalid,
  output logic                    m1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic [BURST_WIDTH-1:0]  m0_burstcount,
  input  logic [BURST_WIDTH-1:0]  m1_burstcount,
  input  logic [DATA_WIDTH-1:0]   m0_writedata,
  input  logic [DATA_WIDTH-1:0]   m1_writedata,
  input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
  input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
  input  logic                    m0_write,
  input  logic                    m0_read,
  input  logic                    m1_write,
  input  logic                    m1_read,
  input  logic                    s_waitrequest,
  input  logic [DATA_WIDTH-1:0]   s_readdata,
  input  logic                    s_readdatavalid,
  output logic [ADDR_WIDTH-1:0]   s_address,
  output logic [BURST_WIDTH-1:0]  s_burstcount,
  output logic [DATA_WIDTH-1:0]   s_writedata,
  output logic [DATA_WIDTH/8-1:0] s_byteenable,
  output logic                    s_write,
  output logic                    s_read
);
  t_arb_state state_q, state_d;
  t_arb_id lock_q, lock_d, sel, pick;
  logic [BURST_WIDTH-1:0] beats_q, beats_d, bc_raw, bc;
  t_len rd_beat_q, rd_beat_d;
  t_rd_tag head;
  logic full, empty, e0, e1, busy, go, wr, rd, legal, accept, rvalid, pop;
  assign e0 = m0_write | (m0_read & ~full);
  assign e1 = m1_write | (m1_read & ~full);
`ifdef AVMM_ARB_FIXED_PRIO_EN
  assign pick = ~e0;
`else
  logic rr_last_q;
  assign pick = (e0 & e1) ? ~rr_last_q : e1;
  always_ff @(posedge clk or posedge reset)
    if (reset) rr_last_q <= 1'b1;
    else if (accept) rr_last_q <= sel;
`endif
  assign busy = state_q == WR_BURST;
  assign sel = busy ? lock_q : pick;
  // reset gates the strobes and stalls combinationally so nothing leaks while it is held
  assign go = ~reset & (busy | e0 | e1);
  assign wr = sel ? m1_write : m0_write;
  assign rd = sel ? m1_read : m0_read;
  assign s_write = go & wr;
  assign s_read = go & ~busy & ~wr & rd & ~full;
  assign s_address = sel ? m1_address : m0_address;
  assign s_burstcount = sel ? m1_burstcount : m0_burstcount;
  assign s_writedata = sel ? m1_writedata : m0_writedata;
  assign s_byteenable = sel ? m1_byteenable : m0_byteenable;
  assign m0_waitrequest = ~(go & ~sel) | s_waitrequest;
  assign m1_waitrequest = ~(go & sel) | s_waitrequest;
  assign accept = (s_write | s_read) & ~s_waitrequest;
  assign bc_raw = s_burstcount;
  assign legal = bc_raw != '0 && bc_raw <= BURST_WIDTH'(ARB_MAX_BURST);
  assign bc = legal ? bc_raw : BURST_WIDTH'(1);
  always_comb begin
    state_d = state_q;
    lock_d = lock_q;
    beats_d = beats_q;
    if (accept && s_write) begin
      if (busy) begin
        beats_d = beats_q - BURST_WIDTH'(1);
        state_d = beats_q == BURST_WIDTH'(1) ? IDLE : WR_BURST;
      end else if (bc != BURST_WIDTH'(1)) begin
        state_d = WR_BURST;
        lock_d = sel;
        beats_d = bc - BURST_WIDTH'(1);
      end
    end
  end
  avmm_arb_tag_fifo #(.DEPTH(MAX_PENDING_READS)) u_tags (
    .clk      (clk),
    .reset    (reset),
    .push     (accept & s_read),
    .push_tag ('{id: sel, len: t_len'(bc)}),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );
  // read beats belong to the oldest outstanding burst; stray beats with no tag are dropped
  assign rvalid = s_readdatavalid & ~empty;
  assign pop = rvalid & (rd_beat_q == head.len - t_len'(1));
  assign rd_beat_d = pop ? '0 : rd_beat_q + t_len'(rvalid);
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign m0_readdatavalid = rvalid & ~head.id;
  assign m1_readdatavalid = rvalid & head.id;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      lock_q <= 1'b0;
      beats_q <= '0;
      rd_beat_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
      beats_q <= beats_d;
      rd_beat_q <= rd_beat_d;
    end
  a_no_orphan_beat: assert property (@(posedge clk) disable iff (reset) !(s_readdatavalid && empty));
  a_legal_burst: assert property (@(posedge clk) disable iff (reset) !(accept && !legal));
endmodule

// File: tb/tb_avmm_ddr_arbiter.sv
// tb_avmm_ddr_arbiter: scenario tasks plus a randomized read-traffic model for avmm_ddr_arbiter
module tb_avmm_ddr_arbiter;
  localparam int DW = 512, AW = 32, BW = 3, NP = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata, m0_writedata, m1_writedata, s_readdata, s_writedata;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic [BW-1:0] m0_burstcount, m1_burstcount, s_burstcount;
  logic [DW/8-1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic m0_write, m0_read, m1_write, m1_read, s_waitrequest, s_readdatavalid, s_write, s_read;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  avmm_ddr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW), .MAX_PENDING_READS(NP)) dut (
    .clk(clk), .reset(reset),
    .m0_waitrequest(m0_waitrequest), .m1_waitrequest(m1_waitrequest),
    .m0_readdata(m0_readdata), .m1_readdata(m1_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m1_readdatavalid(m1_readdatavalid),
    .m0_address(m0_address), .m1_address(m1_address),
    .m0_burstcount(m0_burstcount), .m1_burstcount(m1_burstcount),
    .m0_writedata(m0_writedata), .m1_writedata(m1_writedata),
    .m0_byteenable(m0_byteenable), .m1_byteenable(m1_byteenable),
    .m0_write(m0_write), .m0_read(m0_read), .m1_write(m1_write), .m1_read(m1_read),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_write(s_write), .s_read(s_read)
  );

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {m0_write, m0_read, m1_write, m1_read, s_waitrequest, s_readdatavalid} = '0;
    m0_address = '0; m1_address = '0; m0_burstcount = 3'd1; m1_burstcount = 3'd1;
    m0_writedata = '0; m1_writedata = '0; m0_byteenable = '1; m1_byteenable = '1;
    s_readdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    idle_inputs();
    reset = 1'b1;
    m0_write = 1'b1; m1_read = 1'b1; s_readdatavalid = 1'b1; s_readdata = rnd_data();
    @(negedge clk);
    got = {s_write, s_read, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid};
    vectors++;
    if (got !== 6'b001100) begin miscompares++; $display("FAIL reset_outputs got %b want 001100", got); end
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alternating_writes();
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic [DW/8-1:0] be [2];
    logic [639:0] got, exp;
    int w = 0;
    do_reset();
    for (int m = 0; m < 2; m++) begin a[m] = $urandom; d[m] = rnd_data(); be[m] = {$urandom, $urandom}; end
    m0_write = 1'b1; m1_write = 1'b1;
    for (int c = 0; c < 8; c++) begin
      m0_address = a[0]; m0_writedata = d[0]; m0_byteenable = be[0];
      m1_address = a[1]; m1_writedata = d[1]; m1_byteenable = be[1];
      @(negedge clk);
      got = 640'({s_write, s_address, s_writedata, s_byteenable, m0_waitrequest, m1_waitrequest});
      exp = 640'({1'b1, a[w], d[w], be[w], w == 1, w == 0});
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL alt_wr[%0d] got %h want %h", c, got, exp); end
      tick();
      a[w] = $urandom; d[w] = rnd_data(); be[w] = {$urandom, $urandom};
      w = 1 - w;
    end
    idle_inputs();
  endtask

  task automatic test_write_burst_lock();
    logic [AW-1:0] a1;
    logic [BW-1:0] b1;
    logic [DW-1:0] d;
    logic [639:0] got, exp;
    do_reset();
    a1 = $urandom; b1 = BW'($urandom_range(1, 4));
    m0_write = 1'b1; m0_address = 32'h1000; m0_burstcount = 3'd4;
    m1_read = 1'b1; m1_address = a1; m1_burstcount = b1;
    for (int b = 0; b < 4; b++) begin
      d = rnd_data();
      m0_writedata = d;
      @(negedge clk);
      got = 640'({s_write, s_read, s_address, s_writedata, s_burstcount, m0_waitrequest, m1_waitrequest});
      exp = 640'({1'b1, 1'b0, 32'h1000, d, 3'd4, 1'b0, 1'b1});
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL burst_lock_beat[%0d] got %h want %h", b, got, exp); end
      tick();
    end
    m0_write = 1'b0;
    @(negedge clk);
    got = 640'({s_write, s_read, s_address, s_burstcount, m0_waitrequest, m1_waitrequest});
    exp = 640'({1'b0, 1'b1, a1, b1, 1'b1, 1'b0});
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL burst_then_read got %h want %h", got, exp); end
    tick();
    idle_inputs();
  endtask

  task automatic test_read_return();
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d;
    logic [1100:0] got, exp;
    do_reset();
    a0 = $urandom; a1 = $urandom;
    m0_read = 1'b1; m0_address = a0; m0_burstcount = 3'd2;
    m1_read = 1'b1; m1_address = a1; m1_burstcount = 3'd3;
    @(negedge clk);
    got = 1101'({s_read, s_address, s_burstcount, m0_waitrequest, m1_waitrequest});
    exp = 1101'({1'b1, a0, 3'd2, 1'b0, 1'b1});
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rd_issue_m0 got %h want %h", got, exp); end
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    got = 1101'({s_read, s_address, s_burstcount, m0_waitrequest, m1_waitrequest});
    exp = 1101'({1'b1, a1, 3'd3, 1'b1, 1'b0});
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rd_issue_m1 got %h want %h", got, exp); end
    tick();
    m1_read = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      d = rnd_data();
      s_readdatavalid = 1'b1; s_readdata = d;
      @(negedge clk);
      got = 1101'({m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata});
      exp = 1101'({k < 2, k >= 2, d, d});
      vectors++;
      if (got[1025:1024] !== exp[1025:1024] || got !== exp)
        begin miscompares++; $display("FAIL rd_beat[%0d] valids got %b want %b", k, got[1025:1024], exp[1025:1024]); end
      tick();
    end
    s_readdatavalid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00)
      begin miscompares++; $display("FAIL rd_idle got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    logic [AW-1:0] a1;
    logic [AW+3:0] got, exp;
    do_reset();
    m0_read = 1'b1;
    for (int i = 0; i < NP; i++) begin
      m0_address = AW'(i * 64);
      @(negedge clk);
      vectors++;
      if ({s_read, m0_waitrequest} !== 2'b10)
        begin miscompares++; $display("FAIL fill_read[%0d] got %b want 10", i, {s_read, m0_waitrequest}); end
      tick();
    end
    a1 = $urandom;
    m0_address = 32'h4000;
    m1_write = 1'b1; m1_address = a1;
    @(negedge clk);
    got = {s_read, s_write, s_address, m0_waitrequest, m1_waitrequest};
    exp = {1'b0, 1'b1, a1, 1'b1, 1'b0};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL full_write_wins got %h want %h", got, exp); end
    tick();
    m1_write = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = rnd_data();
    @(negedge clk);
    vectors++;
    if ({s_read, m0_waitrequest, m0_readdatavalid} !== 3'b011)
      begin miscompares++; $display("FAIL full_pop_cycle got %b want 011", {s_read, m0_waitrequest, m0_readdatavalid}); end
    tick();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    got = {2'b00, s_read, s_address, m0_waitrequest};
    exp = {2'b00, 1'b1, 32'h4000, 1'b0};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL read_after_free got %h want %h", got, exp); end
    tick();
    idle_inputs();
  endtask

  task automatic test_burst_stall();
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d;
    logic [599:0] got, exp;
    do_reset();
    a0 = $urandom; a1 = $urandom;
    m0_write = 1'b1; m0_address = a0; m0_burstcount = 3'd4;
    m1_write = 1'b1; m1_address = a1;
    for (int b = 0; b < 4; b++) begin
      d = rnd_data();
      m0_writedata = d;
      if (b == 1) begin
        s_waitrequest = 1'b1;
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          got = 600'({s_write, s_address, s_writedata, m0_waitrequest, m1_waitrequest});
          exp = 600'({1'b1, a0, d, 1'b1, 1'b1});
          vectors++;
          if (got !== exp) begin miscompares++; $display("FAIL stall_hold[%0d] got %h want %h", s, got, exp); end
          tick();
        end
        s_waitrequest = 1'b0;
      end
      @(negedge clk);
      got = 600'({s_write, s_address, s_writedata, m0_waitrequest, m1_waitrequest});
      exp = 600'({1'b1, a0, d, 1'b0, 1'b1});
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL stall_beat[%0d] got %h want %h", b, got, exp); end
      tick();
    end
    m0_write = 1'b0;
    @(negedge clk);
    got = 600'({s_write, s_address, m0_waitrequest, m1_waitrequest});
    exp = 600'({1'b1, a1, 1'b1, 1'b0});
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL stall_release_m1 got %h want %h", got, exp); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_abort();
    logic [AW-1:0] a0, a1;
    logic [AW+3:0] got, exp;
    do_reset();
    a0 = $urandom; a1 = $urandom;
    m0_read = 1'b1;
    repeat (3) tick();
    m0_read = 1'b0;
    m0_write = 1'b1; m0_address = a0; m0_burstcount = 3'd4;
    tick();
    m1_write = 1'b1; m1_address = a1;
    @(negedge clk);
    vectors++;
    if ({s_write, m0_waitrequest, m1_waitrequest} !== 3'b101)
      begin miscompares++; $display("FAIL abort_in_burst got %b want 101", {s_write, m0_waitrequest, m1_waitrequest}); end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({s_write, s_read, m0_waitrequest, m1_waitrequest} !== 4'b0011)
      begin miscompares++; $display("FAIL abort_immediate got %b want 0011", {s_write, s_read, m0_waitrequest, m1_waitrequest}); end
    s_readdatavalid = 1'b1;
    #1;
    vectors++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00)
      begin miscompares++; $display("FAIL abort_rvalid got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
    tick();
    tick();
    s_readdatavalid = 1'b0;
    m0_burstcount = 3'd1;
    reset = 1'b0;
    @(negedge clk);
    got = {s_write, s_address, m0_waitrequest, m1_waitrequest, 2'b00};
    exp = {1'b1, a0, 1'b0, 1'b1, 2'b00};
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL abort_m0_first got %h want %h", got, exp); end
    tick();
    m0_write = 1'b0; m1_write = 1'b0;
    tick();
    m0_read = 1'b1;
    for (int i = 0; i < NP; i++) begin
      @(negedge clk);
      vectors++;
      if ({s_read, m0_waitrequest} !== 2'b10)
        begin miscompares++; $display("FAIL abort_fifo_empty[%0d] got %b want 10", i, {s_read, m0_waitrequest}); end
      tick();
    end
    idle_inputs();
  endtask

  typedef struct {int id; int len;} tag_t;

  task automatic test_random_reads();
    tag_t tags [$];
    int beats = 0, last = 1, win;
    bit req [2], any, rv, el0, el1;
    logic [AW-1:0] ad [2];
    logic [BW-1:0] bcv [2];
    logic [DW-1:0] d;
    logic [5:0] got, exp;
    do_reset();
    req[0] = 0; req[1] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int m = 0; m < 2; m++)
        if (!req[m] && $urandom_range(0, 2) != 0) begin
          req[m] = 1; ad[m] = $urandom; bcv[m] = BW'($urandom_range(1, 4));
        end
      s_waitrequest = $urandom_range(0, 3) == 0;
      rv = tags.size() > 0 && $urandom_range(0, 2) == 0;
      d = rnd_data();
      m0_read = req[0]; m0_address = ad[0]; m0_burstcount = bcv[0];
      m1_read = req[1]; m1_address = ad[1]; m1_burstcount = bcv[1];
      s_readdatavalid = rv; s_readdata = d;
      el0 = req[0] && tags.size() < NP;
      el1 = req[1] && tags.size() < NP;
      any = el0 || el1;
      win = (el0 && el1) ? 1 - last : (el1 ? 1 : 0);
      @(negedge clk);
      got = {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid};
      exp = {any, 1'b0, (any && win == 0) ? s_waitrequest : 1'b1, (any && win == 1) ? s_waitrequest : 1'b1,
             rv && tags[0].id == 0, rv && tags[0].id == 1};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL rand_rd[%0d] ctl got %b want %b", c, got, exp); end
      if (any) begin
        vectors++;
        if ({s_address, s_burstcount} !== {ad[win], bcv[win]})
          begin miscompares++; $display("FAIL rand_rd[%0d] cmd got %h want %h", c, {s_address, s_burstcount}, {ad[win], bcv[win]}); end
      end
      if (rv) begin
        vectors++;
        if (m0_readdata !== d || m1_readdata !== d)
          begin miscompares++; $display("FAIL rand_rd[%0d] data got %h want %h", c, m0_readdata[63:0], d[63:0]); end
      end
      tick();
      if (rv) begin
        beats++;
        if (beats == tags[0].len) begin void'(tags.pop_front()); beats = 0; end
      end
      if (any && !s_waitrequest) begin
        tags.push_back('{win, int'(bcv[win])});
        req[win] = 0;
        last = win;
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_alternating_writes();
    test_write_burst_lock();
    test_read_return();
    test_fifo_full();
    test_burst_stall();
    test_reset_abort();
    test_random_reads();
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
